mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory stage of the five-stage pipeline. It takes the latched execute-to-memory
// bus and drives the data RAM port. Stores are issued exactly once, in the IDLE
// cycle. A load waits one extra cycle for the synchronous RAM read data. The
// stage then hands a packed result bus to writeback, holding it stable while
// writeback stalls.
//
// Ports
//   clk               sole clock, rising edge
//   reset             synchronous, active-high
//   MEM_valid         slot holds a live instruction (low = flush)
//   EXE_MEM_bus_r     154-bit execute-to-memory bus
//   WB_allow_in       writeback accepts the result this cycle
//   dm_rdata          RAM read data, one cycle after dm_en
//   dm_en/dm_wen/dm_addr/dm_wdata   data RAM port
//   MEM_over          result ready for writeback
//   MEM_WB_bus        118-bit memory-to-writeback bus
//   MEM_wdest         destination register, zero when the slot is empty
//   MEM_bypass_valid/MEM_bypass_value   forwarding of the memory result
//   mem_addr_err      misaligned word access flag
//   MEM_pc            pc of the instruction in this stage
//
// Configuration
//   MEM_ALIGN_CHECK_EN  when defined, a word access with addr[1:0] != 0 raises
//                       mem_addr_err. The RAM access is suppressed, and the
//                       instruction retires as a single-cycle non-load.
//                       When undefined, mem_addr_err is tied low.
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         MEM_valid,
    input  logic [153:0] EXE_MEM_bus_r,
    input  logic         WB_allow_in,
    input  logic [31:0]  dm_rdata,
    output logic         dm_en,
    output logic [3:0]   dm_wen,
    output logic [31:0]  dm_addr,
    output logic [31:0]  dm_wdata,
    output logic         MEM_over,
    output logic [117:0] MEM_WB_bus,
    output logic [4:0]   MEM_wdest,
    output logic         MEM_bypass_valid,
    output logic [31:0]  MEM_bypass_value,
    output logic         mem_addr_err,
    output logic [31:0]  MEM_pc
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] loadResult_q, loadResult_d;

    logic        isLoad, isStore, lsWord, lbSign;
    logic [31:0] storeData, exeResult, loResult, pc;
    logic        hiWrite, loWrite, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0rAddr;
    logic        syscall, eret, rfWen;
    logic [4:0]  rfWdest;

    logic        misalign, effLoad, effStore, inIdle, accessEn;
    logic [3:0]  storeMask;
    logic [7:0]  loadByte;
    logic [31:0] loadFormed, memResult;
    logic        overRaw;

    assign {isLoad, isStore, lsWord, lbSign} = EXE_MEM_bus_r[153:150];
    assign storeData = EXE_MEM_bus_r[149:118];
    assign exeResult = EXE_MEM_bus_r[117:86];
    assign loResult  = EXE_MEM_bus_r[85:54];
    assign {hiWrite, loWrite, mfhi, mflo, mtc0, mfc0} = EXE_MEM_bus_r[53:48];
    assign cp0rAddr  = EXE_MEM_bus_r[47:40];
    assign {syscall, eret, rfWen} = EXE_MEM_bus_r[39:37];
    assign rfWdest   = EXE_MEM_bus_r[36:32];
    assign pc        = EXE_MEM_bus_r[31:0];

    // A misaligned word access is demoted to a plain single-cycle op, so the
    // rest of the stage only needs to look at the effective load/store flags.
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = lsWord & (exeResult[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign effLoad  = isLoad & ~misalign;
    assign effStore = isStore & ~misalign;
    assign inIdle   = (state_q == IDLE);

    // The RAM is touched only in IDLE. That gives every store a single write
    // and every load a single read request, however long writeback stalls.
    assign accessEn  = MEM_valid & inIdle & (effLoad | effStore) & ~reset;
    assign storeMask = lsWord ? 4'b1111 : (4'b0001 << exeResult[1:0]);

    assign dm_en    = accessEn;
    assign dm_wen   = (accessEn & effStore) ? storeMask : 4'b0000;
    assign dm_addr  = exeResult;
    assign dm_wdata = lsWord ? storeData : {4{storeData[7:0]}};

    assign mem_addr_err = MEM_valid & misalign & ~reset;

    // Pick the addressed byte of the read data and extend it for lb/lbu.
    always_comb begin
        loadByte = dm_rdata[7:0];
        case (exeResult[1:0])
            2'd0:    loadByte = dm_rdata[7:0];
            2'd1:    loadByte = dm_rdata[15:8];
            2'd2:    loadByte = dm_rdata[23:16];
            default: loadByte = dm_rdata[31:24];
        endcase
        loadFormed = lsWord ? dm_rdata : {{24{lbSign & loadByte[7]}}, loadByte};
    end

    // The read data is only valid during LOAD_WAIT. It is captured there so
    // that HOLD can replay it while the RAM output moves on.
    assign loadResult_d = (state_q == LOAD_WAIT) ? loadFormed : loadResult_q;

    assign memResult = effLoad ? ((state_q == HOLD) ? loadResult_q : loadFormed)
                               : exeResult;

    // A load result is ready only once it has left IDLE. Everything else is
    // ready in the cycle it arrives. An empty slot is never ready.
    always_comb begin
        overRaw = 1'b0;
        case (state_q)
            IDLE:      overRaw = ~effLoad;
            LOAD_WAIT: overRaw = 1'b1;
            HOLD:      overRaw = 1'b1;
            default:   overRaw = 1'b0;
        endcase
    end

    assign MEM_over = MEM_valid & overRaw & ~reset;

    // Next-state logic. A flush always returns to IDLE. Otherwise a load detours
    // through LOAD_WAIT, and any ready result parks in HOLD until writeback
    // accepts it.
    always_comb begin
        state_d = state_q;
        if (!MEM_valid) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (effLoad)
                        state_d = LOAD_WAIT;
                    else if (!WB_allow_in)
                        state_d = HOLD;
                    else
                        state_d = IDLE;
                end
                LOAD_WAIT: state_d = WB_allow_in ? IDLE : HOLD;
                HOLD:      state_d = WB_allow_in ? IDLE : HOLD;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            loadResult_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            loadResult_q <= loadResult_d;
        end
    end

    // mfhi/mflo/mfc0 results are produced later in writeback, so they cannot
    // be forwarded from here. Likewise a load cannot be forwarded before its
    // data arrives.
    assign MEM_bypass_valid = MEM_valid & rfWen & ~(mfhi | mflo | mfc0)
                              & (~effLoad | ~inIdle);
    assign MEM_bypass_value = memResult;

    assign MEM_wdest = rfWdest & {5{MEM_valid}};
    assign MEM_pc    = pc;

    assign MEM_WB_bus = {rfWen, rfWdest, memResult, loResult,
                         hiWrite, loWrite, mfhi, mflo, mtc0, mfc0,
                         cp0rAddr, syscall, eret, pc};

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Bench for mem_stage. A table of single-cycle vectors is applied from IDLE.
// Hand-written sequences follow for the multi-cycle cases: byte loads, a
// stalled load, a stalled byte store, a flush in LOAD_WAIT and a reset in HOLD.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         MEM_valid;
    logic [153:0] EXE_MEM_bus_r;
    logic         WB_allow_in;
    logic [31:0]  dm_rdata;
    logic         dm_en;
    logic [3:0]   dm_wen;
    logic [31:0]  dm_addr;
    logic [31:0]  dm_wdata;
    logic         MEM_over;
    logic [117:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic         MEM_bypass_valid;
    logic [31:0]  MEM_bypass_value;
    logic         mem_addr_err;
    logic [31:0]  MEM_pc;

    int passCount  = 0;
    int checkCount = 0;

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .MEM_valid        (MEM_valid),
        .EXE_MEM_bus_r    (EXE_MEM_bus_r),
        .WB_allow_in      (WB_allow_in),
        .dm_rdata         (dm_rdata),
        .dm_en            (dm_en),
        .dm_wen           (dm_wen),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .MEM_over         (MEM_over),
        .MEM_WB_bus       (MEM_WB_bus),
        .MEM_wdest        (MEM_wdest),
        .MEM_bypass_valid (MEM_bypass_valid),
        .MEM_bypass_value (MEM_bypass_value),
        .mem_addr_err     (mem_addr_err),
        .MEM_pc           (MEM_pc)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        valid;
        logic        wb;
        logic [153:0] bus;
        logic [31:0] rdata;
        logic        expEn;
        logic [3:0]  expWen;
        logic [31:0] expWdata;
        logic        expOver;
        logic        checkRes;
        logic [31:0] expRes;
        logic        expByp;
        logic        expErr;
    } vec_t;

    vec_t vecs[11];

    // Fixed side fields: lo_result = A5A50000, rf_wdest = 7, everything else 0.
    function automatic logic [153:0] makeBus(input logic ld, input logic st,
                                             input logic lw, input logic lbs,
                                             input logic [31:0] sdata,
                                             input logic [31:0] addr,
                                             input logic rfw, input logic hi,
                                             input logic [31:0] pcv);
        return {ld, st, lw, lbs, sdata, addr, 32'hA5A5_0000,
                1'b0, 1'b0, hi, 1'b0, 1'b0, 1'b0, 8'h00,
                1'b0, 1'b0, rfw, 5'd7, pcv};
    endfunction

    function automatic vec_t mkVec(input string nm, input logic v, input logic w,
                                   input logic [153:0] b, input logic [31:0] rd,
                                   input logic en, input logic [3:0] wen,
                                   input logic [31:0] wd, input logic ov,
                                   input logic cr, input logic [31:0] res,
                                   input logic byp, input logic err);
        vec_t t;
        t.name = nm; t.valid = v; t.wb = w; t.bus = b; t.rdata = rd;
        t.expEn = en; t.expWen = wen; t.expWdata = wd; t.expOver = ov;
        t.checkRes = cr; t.expRes = res; t.expByp = byp; t.expErr = err;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input logic v, input logic w,
                                 input logic [153:0] b, input logic [31:0] rd);
        MEM_valid     = v;
        WB_allow_in   = w;
        EXE_MEM_bus_r = b;
        dm_rdata      = rd;
    endtask

    // Empty the slot for one edge so the next test starts from IDLE.
    task automatic flushSlot();
        @(negedge clk);
        MEM_valid   = 1'b0;
        WB_allow_in = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [153:0] busA;
        logic [117:0] expBus;
        int           enCount;
        int           wenCount;
        logic [3:0]   wenSeen;

        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, makeBus(0, 1, 1, 0, 32'hDEADBEEF, 32'h100, 0, 0, 32'h0), 32'h0);

        // Outputs must stay quiet under reset even with a live store presented.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #2;
            checkOutput("rst_dm_en",  dm_en,        1'b0);
            checkOutput("rst_dm_wen", dm_wen,       4'b0000);
            checkOutput("rst_over",   MEM_over,     1'b0);
            checkOutput("rst_err",    mem_addr_err, 1'b0);
        end
        @(negedge clk);
        reset     = 1'b0;
        MEM_valid = 1'b0;
        @(negedge clk);

        vecs[0] = mkVec("sw_word", 1, 1, makeBus(0,1,1,0,32'hDEADBEEF,32'h100,0,0,32'h400000), 32'h0,
                        1, 4'b1111, 32'hDEADBEEF, 1, 1, 32'h100, 0, 0);
        vecs[1] = mkVec("sb_off1", 1, 1, makeBus(0,1,0,0,32'h123456AB,32'h101,0,0,32'h400004), 32'h0,
                        1, 4'b0010, 32'hABABABAB, 1, 1, 32'h101, 0, 0);
        vecs[2] = mkVec("sb_off3", 1, 1, makeBus(0,1,0,0,32'h000000C7,32'h103,0,0,32'h400008), 32'h0,
                        1, 4'b1000, 32'hC7C7C7C7, 1, 1, 32'h103, 0, 0);
        vecs[3] = mkVec("sb_off0", 1, 1, makeBus(0,1,0,0,32'h00000011,32'h200,0,0,32'h40000C), 32'h0,
                        1, 4'b0001, 32'h11111111, 1, 1, 32'h200, 0, 0);
        vecs[4] = mkVec("alu", 1, 1, makeBus(0,0,0,0,32'h0,32'h12345678,1,0,32'h400010), 32'h0,
                        0, 4'b0000, 32'h0, 1, 1, 32'h12345678, 1, 0);
        vecs[5] = mkVec("mfhi", 1, 1, makeBus(0,0,0,0,32'h0,32'h0BADCAFE,1,1,32'h400014), 32'h0,
                        0, 4'b0000, 32'h0, 1, 1, 32'h0BADCAFE, 0, 0);
        vecs[6] = mkVec("lw_idle", 1, 1, makeBus(1,0,1,0,32'h0,32'h200,1,0,32'h400018), 32'h0,
                        1, 4'b0000, 32'h0, 0, 0, 32'h0, 0, 0);
        vecs[7] = mkVec("invalid_sw", 0, 1, makeBus(0,1,1,0,32'hFFFFFFFF,32'h104,1,0,32'h40001C), 32'h0,
                        0, 4'b0000, 32'h0, 0, 1, 32'h104, 0, 0);
        vecs[8] = mkVec("alu_stall", 1, 0, makeBus(0,0,0,0,32'h0,32'h55,1,0,32'h400020), 32'h0,
                        0, 4'b0000, 32'h0, 1, 1, 32'h55, 1, 0);
`ifdef MEM_ALIGN_CHECK_EN
        vecs[9] = mkVec("sw_mis", 1, 1, makeBus(0,1,1,0,32'hCAFEBABE,32'h102,0,0,32'h400024), 32'h0,
                        0, 4'b0000, 32'h0, 1, 1, 32'h102, 0, 1);
        vecs[10] = mkVec("lw_mis", 1, 1, makeBus(1,0,1,0,32'h0,32'h102,1,0,32'h400028), 32'h77,
                         0, 4'b0000, 32'h0, 1, 1, 32'h102, 1, 1);
`else
        vecs[9] = mkVec("sw_mis", 1, 1, makeBus(0,1,1,0,32'hCAFEBABE,32'h102,0,0,32'h400024), 32'h0,
                        1, 4'b1111, 32'hCAFEBABE, 1, 1, 32'h102, 0, 0);
        vecs[10] = mkVec("lw_mis", 1, 1, makeBus(1,0,1,0,32'h0,32'h102,1,0,32'h400028), 32'h77,
                         1, 4'b0000, 32'h0, 0, 0, 32'h0, 0, 0);
`endif

        // Table vectors: each one is applied in IDLE and checked in that cycle.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].wb, vecs[i].bus, vecs[i].rdata);
            #2;
            checkOutput({vecs[i].name, "_en"},   dm_en,            vecs[i].expEn);
            checkOutput({vecs[i].name, "_wen"},  dm_wen,           vecs[i].expWen);
            if (vecs[i].expWen != 4'b0000)
                checkOutput({vecs[i].name, "_wdata"}, dm_wdata, vecs[i].expWdata);
            checkOutput({vecs[i].name, "_over"}, MEM_over,         vecs[i].expOver);
            if (vecs[i].checkRes)
                checkOutput({vecs[i].name, "_res"}, MEM_bypass_value, vecs[i].expRes);
            checkOutput({vecs[i].name, "_byp"},  MEM_bypass_valid, vecs[i].expByp);
            checkOutput({vecs[i].name, "_err"},  mem_addr_err,     vecs[i].expErr);
            checkOutput({vecs[i].name, "_addr"}, dm_addr,          vecs[i].bus[117:86]);
            flushSlot();
        end

        // Signed and unsigned byte loads from offset 3 of 0x80112233.
        for (int s = 1; s >= 0; s--) begin
            busA = makeBus(1, 0, 0, s[0], 32'h0, 32'h103, 1, 0, 32'h00400100);
            applyStimulus(1'b1, 1'b1, busA, 32'h0);
            #2;
            checkOutput("lb_c1_over", MEM_over, 1'b0);
            checkOutput("lb_c1_en",   dm_en,    1'b1);
            @(negedge clk);
            dm_rdata = 32'h80112233;
            #2;
            expBus = {1'b1, 5'd7, (s == 1) ? 32'hFFFFFF80 : 32'h00000080, 32'hA5A5_0000,
                      6'b000000, 8'h00, 2'b00, 32'h00400100};
            checkOutput("lb_c2_over", MEM_over,         1'b1);
            checkOutput("lb_c2_en",   dm_en,            1'b0);
            checkOutput("lb_c2_res",  MEM_bypass_value, (s == 1) ? 32'hFFFFFF80 : 32'h00000080);
            checkOutput("lb_c2_byp",  MEM_bypass_valid, 1'b1);
            checkOutput("lb_c2_bus",  MEM_WB_bus,       expBus);
            checkOutput("lb_c2_pc",   MEM_pc,           32'h00400100);
            flushSlot();
        end

        // Word load stalled by writeback for three cycles.
        enCount = 0;
        applyStimulus(1'b1, 1'b0, makeBus(1, 0, 1, 0, 32'h0, 32'h300, 1, 0, 32'h00400200), 32'h0);
        #2;
        enCount += int'(dm_en);
        @(negedge clk);
        dm_rdata = 32'hCAFEF00D;
        #2;
        enCount += int'(dm_en);
        checkOutput("lwst_lw_over", MEM_over,         1'b1);
        checkOutput("lwst_lw_res",  MEM_bypass_value, 32'hCAFEF00D);
        @(negedge clk);
        dm_rdata = 32'h11111111;
        #2;
        enCount += int'(dm_en);
        checkOutput("lwst_h1_over", MEM_over,         1'b1);
        checkOutput("lwst_h1_res",  MEM_bypass_value, 32'hCAFEF00D);
        @(negedge clk);
        dm_rdata    = 32'h22222222;
        WB_allow_in = 1'b1;
        #2;
        enCount += int'(dm_en);
        checkOutput("lwst_h2_over",  MEM_over,         1'b1);
        checkOutput("lwst_h2_res",   MEM_bypass_value, 32'hCAFEF00D);
        checkOutput("lwst_h2_wdest", MEM_wdest,        5'd7);
        @(negedge clk);
        MEM_valid = 1'b0;
        #2;
        checkOutput("lwst_en_pulses", enCount,   1);
        checkOutput("lwst_done_over", MEM_over,  1'b0);
        checkOutput("lwst_wdest_off", MEM_wdest, 5'd0);
        @(negedge clk);

        // Byte store to 0x102 held for two stall cycles: exactly one write.
        wenCount = 0;
        wenSeen  = 4'b0000;
        applyStimulus(1'b1, 1'b0, makeBus(0, 1, 0, 0, 32'h0000003C, 32'h102, 0, 0, 32'h00400300), 32'h0);
        for (int c = 0; c < 3; c++) begin
            if (c == 2)
                WB_allow_in = 1'b1;
            #2;
            if (dm_wen != 4'b0000) begin
                wenCount++;
                wenSeen = dm_wen;
            end
            checkOutput("sbst_over", MEM_over, 1'b1);
            @(negedge clk);
        end
        checkOutput("sbst_wen_count", wenCount, 1);
        checkOutput("sbst_wen_value", wenSeen,  4'b0100);
        checkOutput("sbst_wdata",     dm_wdata, 32'h3C3C3C3C);
        flushSlot();

        // Flush while in LOAD_WAIT, then prove IDLE by issuing a store.
        applyStimulus(1'b1, 1'b1, makeBus(1, 0, 1, 0, 32'h0, 32'h400, 1, 0, 32'h00400400), 32'h0);
        @(negedge clk);
        MEM_valid = 1'b0;
        #2;
        checkOutput("flush_over", MEM_over, 1'b0);
        checkOutput("flush_en",   dm_en,    1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, makeBus(0, 1, 1, 0, 32'h01020304, 32'h404, 0, 0, 32'h00400404), 32'h0);
        #2;
        checkOutput("flush_idle_en",  dm_en,  1'b1);
        checkOutput("flush_idle_wen", dm_wen, 4'b1111);
        flushSlot();

        // Reset asserted while in HOLD.
        applyStimulus(1'b1, 1'b0, makeBus(0, 0, 0, 0, 32'h0, 32'h77, 1, 0, 32'h00400500), 32'h0);
        @(negedge clk);
        #2;
        checkOutput("hold_over", MEM_over, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, makeBus(0, 1, 1, 0, 32'hAAAA5555, 32'h500, 0, 0, 32'h00400504), 32'h0);
        #2;
        checkOutput("rsth_over", MEM_over, 1'b0);
        checkOutput("rsth_en",   dm_en,    1'b0);
        checkOutput("rsth_wen",  dm_wen,   4'b0000);
        @(negedge clk);
        reset       = 1'b0;
        WB_allow_in = 1'b1;
        #2;
        checkOutput("rsth_idle_en",  dm_en,    1'b1);
        checkOutput("rsth_idle_wen", dm_wen,   4'b1111);
        checkOutput("rsth_idle_over", MEM_over, 1'b1);
        flushSlot();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
